// File: rtl/bram_port_arbiter.sv
// Arbitrates the shared single-port 1024x32 block RAM between instruction fetch
// and byte-addressed load/store, with lane steering and load alignment/extension.
module bram_port_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [9:0]  i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [11:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [9:0]  ram_addr,
    output logic [31:0] ram_di,
    input  logic [31:0] ram_dout
);

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    size_e       size_in;
    logic        mis;
    logic [3:0]  streak;
    logic        streak_full;
    logic        d_use;
    logic        d_bad;

    logic        ld_q;
    logic [1:0]  off_q;
    size_e       size_q;
    logic        uns_q;
    logic [31:0] shifted;

    assign size_in     = size_e'(d_size);
    assign streak_full = (streak == STREAK_MAX);

    always_comb begin
        mis = 1'b0;
        case (size_in)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = d_addr[0];
            SZ_WORD: mis = |d_addr[1:0];
            default: mis = 1'b1;
        endcase
    end

    // A misaligned data request never touches the RAM, so a waiting fetch rides along.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst_n) begin
            if (d_req && mis) begin
                d_gnt = 1'b1;
                i_gnt = i_req;
            end else if (d_req && !(i_req && streak_full)) begin
                d_gnt = 1'b1;
            end else begin
                i_gnt = i_req;
            end
        end
    end

    assign d_use = d_gnt & ~mis;
    assign d_bad = d_gnt & mis;

    always_comb begin
        ram_en   = 1'b0;
        ram_we   = '0;
        ram_addr = '0;
        ram_di   = '0;
        if (d_use) begin
            ram_en   = 1'b1;
            ram_addr = d_addr[11:2];
            if (d_we) begin
                case (size_in)
                    SZ_BYTE: begin
                        ram_we = 4'b0001 << d_addr[1:0];
                        ram_di = {4{d_wdata[7:0]}};
                    end
                    SZ_HALF: begin
                        ram_we = 4'b0011 << d_addr[1:0];
                        ram_di = {2{d_wdata[15:0]}};
                    end
                    default: begin
                        ram_we = 4'b1111;
                        ram_di = d_wdata;
                    end
                endcase
            end
        end else if (i_gnt) begin
            ram_en   = 1'b1;
            ram_addr = i_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (i_gnt || !i_req) begin
            streak <= '0;
        end else if (d_use && !streak_full) begin
            streak <= streak + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            d_err    <= 1'b0;
            ld_q     <= 1'b0;
            off_q    <= '0;
            size_q   <= SZ_BYTE;
            uns_q    <= 1'b0;
        end else begin
            i_rvalid <= i_gnt;
            d_rvalid <= d_use;
            d_err    <= d_bad;
            ld_q     <= d_use & ~d_we;
            if (d_use) begin
                off_q  <= d_addr[1:0];
                size_q <= size_in;
                uns_q  <= d_unsigned;
            end
        end
    end

    assign i_rdata = i_rvalid ? ram_dout : '0;
    assign shifted = ram_dout >> {off_q, 3'b000};

    always_comb begin
        d_rdata = '0;
        if (ld_q) begin
            case (size_q)
                SZ_BYTE: d_rdata = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
                SZ_HALF: d_rdata = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
                default: d_rdata = shifted;
            endcase
        end
    end

endmodule
